// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the writeback path.
//   src_e   : identifies a result producer (ALU, load unit, long-latency unit)
//   REG_AW  : architectural register address width
//   XLEN    : default datapath width
// ---------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_LONG = 2'd2
  } src_e;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

endpackage

// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
// One pending-write bit per architectural register. Register 0 never has a
// pending write.
//   clk, rst             : clock, synchronous active-high reset
//   set_valid, set_rd    : an issued instruction will write set_rd
//   clr_valid, clr_rd    : a writeback to clr_rd commits this cycle
//   q0_rd..q2_rd         : query addresses
//   q0_busy..q2_busy     : combinational pending status of each query
// ---------------------------------------------------------------------------
module wb_scoreboard
  import core_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_valid,
  input  logic [4:0] set_rd,
  input  logic       clr_valid,
  input  logic [4:0] clr_rd,
  input  logic [4:0] q0_rd,
  input  logic [4:0] q1_rd,
  input  logic [4:0] q2_rd,
  output logic       q0_busy,
  output logic       q1_busy,
  output logic       q2_busy
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Clear is applied before set so that an issue to the same register in the
  // cycle its previous write commits leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (clr_valid) pending_d[clr_rd] = 1'b0;
    if (set_valid) pending_d[set_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign q0_busy = (q0_rd != 5'd0) && pending_q[q0_rd];
  assign q1_busy = (q1_rd != 5'd0) && pending_q[q1_rd];
  assign q2_busy = (q2_rd != 5'd0) && pending_q[q2_rd];

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Merges ALU, load-unit and long-latency-unit results onto the single
// register-file write port and tracks in-flight destination registers.
//   clk, rst                          : clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data         : ALU result, always accepted
//   ld_valid/ld_ready/ld_rd/ld_data   : load-unit result handshake
//   lg_valid/lg_ready/lg_rd/lg_data   : long-latency-unit result handshake
//   issue_valid/issue_rd              : issued instruction destination
//   rs1, rs2                          : issue-stage source operands
//   rs1_busy/rs2_busy/issue_rd_busy   : pending-write status (combinational)
//   wb_rd/rddata/we                   : registered register-file write port
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            lg_valid,
  output logic            lg_ready,
  input  logic [4:0]      lg_rd,
  input  logic [XLEN-1:0] lg_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            issue_rd_busy,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] rddata,
  output logic            we
);

  import core_pkg::*;

  src_e            rr_q, rr_d;
  logic            we_q, we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] rddata_q, rddata_d;
  logic            ld_fire, lg_fire;

  // A ready never looks at its own valid; the contender's valid and the
  // round-robin pointer decide who gets the port when the ALU is idle.
  assign ld_ready = !rst && !alu_valid && (!lg_valid || rr_q == SRC_LOAD);
  assign lg_ready = !rst && !alu_valid && (!ld_valid || rr_q == SRC_LONG);
  assign ld_fire  = ld_valid && ld_ready;
  assign lg_fire  = lg_valid && lg_ready;

  always_comb begin
    rr_d     = rr_q;
    we_d     = 1'b0;
    wb_rd_d  = wb_rd_q;
    rddata_d = rddata_q;
    if (alu_valid) begin
      we_d     = (alu_rd != 5'd0);
      wb_rd_d  = alu_rd;
      rddata_d = alu_data;
    end else if (ld_fire) begin
      we_d     = (ld_rd != 5'd0);
      wb_rd_d  = ld_rd;
      rddata_d = ld_data;
      rr_d     = SRC_LONG;
    end else if (lg_fire) begin
      we_d     = (lg_rd != 5'd0);
      wb_rd_d  = lg_rd;
      rddata_d = lg_data;
      rr_d     = SRC_LOAD;
    end
  end

  // Writeback stage: the granted result is presented to the register file
  // one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= SRC_LOAD;
      we_q     <= 1'b0;
      wb_rd_q  <= 5'd0;
      rddata_q <= '0;
    end else begin
      rr_q     <= rr_d;
      we_q     <= we_d;
      wb_rd_q  <= wb_rd_d;
      rddata_q <= rddata_d;
    end
  end

  assign we     = we_q;
  assign wb_rd  = wb_rd_q;
  assign rddata = rddata_q;

  // The pending bit is cleared on the same edge the register file writes,
  // so busy drops exactly when the new value becomes readable.
  wb_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (issue_valid && issue_rd != 5'd0),
    .set_rd    (issue_rd),
    .clr_valid (we_q),
    .clr_rd    (wb_rd_q),
    .q0_rd     (rs1),
    .q1_rd     (rs2),
    .q2_rd     (issue_rd),
    .q0_busy   (rs1_busy),
    .q1_busy   (rs2_busy),
    .q2_busy   (issue_rd_busy)
  );

  // Issue must stall on a pending destination; WAW ordering relies on it.
  always_ff @(posedge clk) begin
    if (!rst && issue_valid) begin
      assert (!issue_rd_busy)
        else $error("wb_arbiter: issue to rd %0d while a write is pending", issue_rd);
    end
  end

endmodule
